emulib_axi_arbiter_2to1: RTL and testbench

Two-to-one AXI4 arbiter that shares a single downstream AXI4 master port, such as a register-sliced memory path, between two upstream AXI4 masters. The read and write directions are arbitrated independently, each with round-robin priority. Each direction holds at most one outstanding transaction: the grant stays with its owner until the full burst and response complete. It sits in front of shared emulated-memory resources in emulib.

---
 rtl/emulib_axi_arbiter_2to1.sv | 278 +++++++++++++++++++++++++++
 tb/tb_emulib_axi_arbiter_2to1.sv | 545 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emulib_axi_arbiter_2to1.sv
// Two-to-one AXI4 arbiter: independent round-robin read and write grants,
// one outstanding transaction per direction, payloads muxed combinationally.
module emulib_axi_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  // slave port 0
  input  logic [ID_WIDTH-1:0]       s0_awid,
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic [7:0]                s0_awlen,
  input  logic [2:0]                s0_awsize,
  input  logic [1:0]                s0_awburst,
  input  logic                      s0_awlock,
  input  logic [3:0]                s0_awcache,
  input  logic [2:0]                s0_awprot,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wlast,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [ID_WIDTH-1:0]       s0_bid,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ID_WIDTH-1:0]       s0_arid,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic [7:0]                s0_arlen,
  input  logic [2:0]                s0_arsize,
  input  logic [1:0]                s0_arburst,
  input  logic                      s0_arlock,
  input  logic [3:0]                s0_arcache,
  input  logic [2:0]                s0_arprot,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [ID_WIDTH-1:0]       s0_rid,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rlast,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  // slave port 1
  input  logic [ID_WIDTH-1:0]       s1_awid,
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic [7:0]                s1_awlen,
  input  logic [2:0]                s1_awsize,
  input  logic [1:0]                s1_awburst,
  input  logic                      s1_awlock,
  input  logic [3:0]                s1_awcache,
  input  logic [2:0]                s1_awprot,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wlast,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [ID_WIDTH-1:0]       s1_bid,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ID_WIDTH-1:0]       s1_arid,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic [7:0]                s1_arlen,
  input  logic [2:0]                s1_arsize,
  input  logic [1:0]                s1_arburst,
  input  logic                      s1_arlock,
  input  logic [3:0]                s1_arcache,
  input  logic [2:0]                s1_arprot,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [ID_WIDTH-1:0]       s1_rid,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rlast,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  // shared master port
  output logic [ID_WIDTH-1:0]       m_awid,
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awsize,
  output logic [1:0]                m_awburst,
  output logic                      m_awlock,
  output logic [3:0]                m_awcache,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [ID_WIDTH-1:0]       m_bid,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ID_WIDTH-1:0]       m_arid,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  output logic                      m_arlock,
  output logic [3:0]                m_arcache,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [ID_WIDTH-1:0]       m_rid,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE, R_ADDR, R_DATA
  } rstate_t;

  wstate_t w_state, w_next;
  rstate_t r_state, r_next;
  logic    w_own, w_own_nx;
  logic    wr_ptr, wr_ptr_nx;
  logic    r_own, r_own_nx;
  logic    rd_ptr, rd_ptr_nx;

  logic w_adr, w_dat, w_rsp;
  logic r_adr, r_dat;

  assign w_adr = (w_state == W_ADDR);
  assign w_dat = (w_state == W_DATA);
  assign w_rsp = (w_state == W_RESP);
  assign r_adr = (r_state == R_ADDR);
  assign r_dat = (r_state == R_DATA);

  // owner and pointer: 0 selects s0, 1 selects s1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      w_own   <= 1'b0;
      wr_ptr  <= 1'b0;
      r_state <= R_IDLE;
      r_own   <= 1'b0;
      rd_ptr  <= 1'b0;
    end else begin
      w_state <= w_next;
      w_own   <= w_own_nx;
      wr_ptr  <= wr_ptr_nx;
      r_state <= r_next;
      r_own   <= r_own_nx;
      rd_ptr  <= rd_ptr_nx;
    end
  end

  always_comb begin
    w_next    = w_state;
    w_own_nx  = w_own;
    wr_ptr_nx = wr_ptr;
    unique case (w_state)
      W_IDLE: begin
        if (s0_awvalid || s1_awvalid) begin
          w_own_nx = (s0_awvalid && s1_awvalid)
                   ? wr_ptr : s1_awvalid;
          w_next   = W_ADDR;
        end
      end
      W_ADDR: begin
        if (m_awvalid && m_awready)
          w_next = W_DATA;
      end
      W_DATA: begin
        if (m_wvalid && m_wready && m_wlast)
          w_next = W_RESP;
      end
      W_RESP: begin
        if (m_bvalid && m_bready) begin
          w_next    = W_IDLE;
          wr_ptr_nx = ~w_own;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    r_own_nx  = r_own;
    rd_ptr_nx = rd_ptr;
    unique case (r_state)
      R_IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          r_own_nx = (s0_arvalid && s1_arvalid)
                   ? rd_ptr : s1_arvalid;
          r_next   = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_arvalid && m_arready)
          r_next = R_DATA;
      end
      R_DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          r_next    = R_IDLE;
          rd_ptr_nx = ~r_own;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // handshake routing; non-owner and idle sides stay at 0
  always_comb begin
    m_awvalid  = w_adr & (w_own ? s1_awvalid : s0_awvalid);
    s0_awready = w_adr & ~w_own & m_awready;
    s1_awready = w_adr &  w_own & m_awready;

    m_wvalid   = w_dat & (w_own ? s1_wvalid : s0_wvalid);
    s0_wready  = w_dat & ~w_own & m_wready;
    s1_wready  = w_dat &  w_own & m_wready;

    m_bready   = w_rsp & (w_own ? s1_bready : s0_bready);
    s0_bvalid  = w_rsp & ~w_own & m_bvalid;
    s1_bvalid  = w_rsp &  w_own & m_bvalid;

    m_arvalid  = r_adr & (r_own ? s1_arvalid : s0_arvalid);
    s0_arready = r_adr & ~r_own & m_arready;
    s1_arready = r_adr &  r_own & m_arready;

    m_rready   = r_dat & (r_own ? s1_rready : s0_rready);
    s0_rvalid  = r_dat & ~r_own & m_rvalid;
    s1_rvalid  = r_dat &  r_own & m_rvalid;
  end

  assign m_awid    = w_own ? s1_awid    : s0_awid;
  assign m_awaddr  = w_own ? s1_awaddr  : s0_awaddr;
  assign m_awlen   = w_own ? s1_awlen   : s0_awlen;
  assign m_awsize  = w_own ? s1_awsize  : s0_awsize;
  assign m_awburst = w_own ? s1_awburst : s0_awburst;
  assign m_awlock  = w_own ? s1_awlock  : s0_awlock;
  assign m_awcache = w_own ? s1_awcache : s0_awcache;
  assign m_awprot  = w_own ? s1_awprot  : s0_awprot;

  assign m_wdata   = w_own ? s1_wdata   : s0_wdata;
  assign m_wstrb   = w_own ? s1_wstrb   : s0_wstrb;
  assign m_wlast   = w_own ? s1_wlast   : s0_wlast;

  assign s0_bid    = m_bid;
  assign s0_bresp  = m_bresp;
  assign s1_bid    = m_bid;
  assign s1_bresp  = m_bresp;

  assign m_arid    = r_own ? s1_arid    : s0_arid;
  assign m_araddr  = r_own ? s1_araddr  : s0_araddr;
  assign m_arlen   = r_own ? s1_arlen   : s0_arlen;
  assign m_arsize  = r_own ? s1_arsize  : s0_arsize;
  assign m_arburst = r_own ? s1_arburst : s0_arburst;
  assign m_arlock  = r_own ? s1_arlock  : s0_arlock;
  assign m_arcache = r_own ? s1_arcache : s0_arcache;
  assign m_arprot  = r_own ? s1_arprot  : s0_arprot;

  assign s0_rid    = m_rid;
  assign s0_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rid    = m_rid;
  assign s1_rdata  = m_rdata;
  assign s1_rresp  = m_rresp;
  assign s1_rlast  = m_rlast;

endmodule

// File: tb/tb_emulib_axi_arbiter_2to1.sv
// Scoreboard bench for emulib_axi_arbiter_2to1: directed upstream masters,
// a behavioural downstream slave, and a monitor checking every handshake.
module tb_emulib_axi_arbiter_2to1;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW/8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0][IW-1:0] s_awid, s_arid;
  logic [1:0][AW-1:0] s_awaddr, s_araddr;
  logic [1:0][7:0]    s_awlen, s_arlen;
  logic [1:0][2:0]    s_awsize, s_arsize;
  logic [1:0][2:0]    s_awprot, s_arprot;
  logic [1:0][1:0]    s_awburst, s_arburst;
  logic [1:0][3:0]    s_awcache, s_arcache;
  logic [1:0]         s_awlock, s_arlock;
  logic [1:0]         s_awvalid, s_arvalid;
  logic [1:0][DW-1:0] s_wdata;
  logic [1:0][SW-1:0] s_wstrb;
  logic [1:0]         s_wlast, s_wvalid;
  logic [1:0]         s_bready, s_rready;

  logic s0_awready, s0_wready, s0_bvalid;
  logic s0_arready, s0_rvalid, s0_rlast;
  logic s1_awready, s1_wready, s1_bvalid;
  logic s1_arready, s1_rvalid, s1_rlast;
  logic [IW-1:0] s0_bid, s1_bid, s0_rid, s1_rid;
  logic [1:0]    s0_bresp, s1_bresp, s0_rresp, s1_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata;

  logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0]    m_awlen, m_arlen;
  logic [2:0]    m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
  logic          m_awlock, m_arlock;
  logic [3:0]    m_awcache, m_arcache;
  logic          m_awvalid, m_awready, m_arvalid, m_arready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic          m_bvalid, m_bready;
  logic          m_rlast, m_rvalid, m_rready;

  emulib_axi_arbiter_2to1 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s0_awid(s_awid[0]), .s0_awaddr(s_awaddr[0]),
    .s0_awlen(s_awlen[0]), .s0_awsize(s_awsize[0]),
    .s0_awburst(s_awburst[0]), .s0_awlock(s_awlock[0]),
    .s0_awcache(s_awcache[0]), .s0_awprot(s_awprot[0]),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s0_awready),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]),
    .s0_wlast(s_wlast[0]), .s0_wvalid(s_wvalid[0]),
    .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp),
    .s0_bvalid(s0_bvalid), .s0_bready(s_bready[0]),
    .s0_arid(s_arid[0]), .s0_araddr(s_araddr[0]),
    .s0_arlen(s_arlen[0]), .s0_arsize(s_arsize[0]),
    .s0_arburst(s_arburst[0]), .s0_arlock(s_arlock[0]),
    .s0_arcache(s_arcache[0]), .s0_arprot(s_arprot[0]),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s0_arready),
    .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
    .s0_rready(s_rready[0]),
    .s1_awid(s_awid[1]), .s1_awaddr(s_awaddr[1]),
    .s1_awlen(s_awlen[1]), .s1_awsize(s_awsize[1]),
    .s1_awburst(s_awburst[1]), .s1_awlock(s_awlock[1]),
    .s1_awcache(s_awcache[1]), .s1_awprot(s_awprot[1]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s1_awready),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]),
    .s1_wlast(s_wlast[1]), .s1_wvalid(s_wvalid[1]),
    .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp),
    .s1_bvalid(s1_bvalid), .s1_bready(s_bready[1]),
    .s1_arid(s_arid[1]), .s1_araddr(s_araddr[1]),
    .s1_arlen(s_arlen[1]), .s1_arsize(s_arsize[1]),
    .s1_arburst(s_arburst[1]), .s1_arlock(s_arlock[1]),
    .s1_arcache(s_arcache[1]), .s1_arprot(s_arprot[1]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s1_arready),
    .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
    .s1_rready(s_rready[1]),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  wire [1:0] awrdy = {s1_awready, s0_awready};
  wire [1:0] wrdy  = {s1_wready, s0_wready};
  wire [1:0] bvld  = {s1_bvalid, s0_bvalid};
  wire [1:0] arrdy = {s1_arready, s0_arready};
  wire [1:0] rvld  = {s1_rvalid, s0_rvalid};
  wire [14:0] vr = {m_awvalid, m_wvalid, m_bready, m_arvalid,
                    m_rready, s0_awready, s0_wready, s0_bvalid,
                    s0_arready, s0_rvalid, s1_awready, s1_wready,
                    s1_bvalid, s1_arready, s1_rvalid};

  typedef struct packed {
    logic [1:0]    sel;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    prot;
  } a_t;
  typedef struct packed {
    logic [1:0]    sel;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } w_t;
  typedef struct packed {
    logic [1:0]    sel;
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;
  typedef struct packed {
    logic [1:0]    sel;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } r_t;

  a_t qaw[$];
  a_t qar[$];
  w_t qw[$];
  b_t qb[$];
  r_t qr[$];

  int ncmp = 0;
  int nerr = 0;
  int aw_cyc[2];
  int ar_cyc[2];
  int b_cyc[2];
  logic s1_seen = 1'b0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic miss(string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s: handshake with nothing expected", nm);
  endtask

  function automatic logic [1:0] oh(int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [DW-1:0] wd(logic [AW-1:0] a, int b);
    return {a, 24'hA5C300, 8'(b)};
  endfunction

  task automatic exp_wr(int p, logic [IW-1:0] id, logic [AW-1:0] a,
                        int len);
    a_t ea;
    w_t ew;
    b_t eb;
    ea.sel = oh(p); ea.id = id; ea.addr = a;
    ea.len = 8'(len); ea.prot = 3'(p + 1);
    qaw.push_back(ea);
    for (int b = 0; b <= len; b++) begin
      ew.sel = oh(p); ew.data = wd(a, b);
      ew.strb = '1; ew.last = (b == len);
      qw.push_back(ew);
    end
    eb.sel = oh(p); eb.id = id; eb.resp = 2'b00;
    qb.push_back(eb);
  endtask

  task automatic exp_rd(int p, logic [IW-1:0] id, logic [AW-1:0] a,
                        int len);
    a_t ea;
    r_t er;
    ea.sel = oh(p); ea.id = id; ea.addr = a;
    ea.len = 8'(len); ea.prot = 3'(p + 1);
    qar.push_back(ea);
    for (int b = 0; b <= len; b++) begin
      er.sel = oh(p); er.id = id;
      er.data = 64'(a) + 64'(b); er.last = (b == len);
      qr.push_back(er);
    end
  endtask

  // scoreboard monitor
  a_t ma;
  w_t mw;
  b_t mb;
  r_t mr;
  always @(negedge clk) begin
    if ({s1_awready, s1_wready, s1_bvalid,
         s1_arready, s1_rvalid} != 5'b0)
      s1_seen = 1'b1;
    if (resetn) begin
      if (m_awvalid && m_awready) begin
        if (s0_awready) aw_cyc[0] = cyc;
        if (s1_awready) aw_cyc[1] = cyc;
        if (qaw.size() == 0) miss("aw");
        else begin
          ma = qaw.pop_front();
          chk("aw", 128'({awrdy, m_awid, m_awaddr,
                          m_awlen, m_awprot}), 128'(ma));
        end
      end
      if (m_wvalid && m_wready) begin
        if (qw.size() == 0) miss("w");
        else begin
          mw = qw.pop_front();
          chk("w", 128'({wrdy, m_wdata, m_wstrb, m_wlast}),
              128'(mw));
        end
      end
      if (m_bvalid && m_bready) begin
        if (s0_bvalid) b_cyc[0] = cyc;
        if (s1_bvalid) b_cyc[1] = cyc;
        if (qb.size() == 0) miss("b");
        else begin
          mb = qb.pop_front();
          chk("b", 128'({bvld, s1_bvalid ? s1_bid : s0_bid,
                         s1_bvalid ? s1_bresp : s0_bresp}),
              128'(mb));
        end
      end
      if (m_arvalid && m_arready) begin
        if (s0_arready) ar_cyc[0] = cyc;
        if (s1_arready) ar_cyc[1] = cyc;
        if (qar.size() == 0) miss("ar");
        else begin
          ma = qar.pop_front();
          chk("ar", 128'({arrdy, m_arid, m_araddr,
                          m_arlen, m_arprot}), 128'(ma));
        end
      end
      if (m_rvalid && m_rready) begin
        if (qr.size() == 0) miss("r");
        else begin
          mr = qr.pop_front();
          chk("r", 128'({rvld, s1_rvalid ? s1_rid : s0_rid,
                         s1_rvalid ? s1_rdata : s0_rdata,
                         s1_rvalid ? s1_rlast : s0_rlast}),
              128'(mr));
        end
      end
    end
  end

  // downstream write slave: always ready, B after last beat
  initial begin : wslave
    logic [IW-1:0] bid;
    int n;
    bid = '0;
    forever begin
      @(negedge clk);
      if (resetn && m_awvalid && m_awready) bid = m_awid;
      if (resetn && m_wvalid && m_wready && m_wlast) begin
        @(posedge clk); #1;
        m_bid = bid; m_bresp = 2'b00; m_bvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!m_bready && n < 200);
        if (!m_bready) begin
          ncmp++; nerr++;
          $display("FAIL b wait: bready stuck at %b", m_bready);
        end
        @(posedge clk); #1;
        m_bvalid = 1'b0;
      end
    end
  end

  // downstream read slave: beat data is address plus beat index
  initial begin : rslave
    logic [IW-1:0] id;
    logic [AW-1:0] a;
    int len;
    int k;
    forever begin
      @(negedge clk);
      if (resetn && m_arvalid && m_arready) begin
        id = m_arid; a = m_araddr; len = int'(m_arlen);
        @(posedge clk); #1;
        for (int b = 0; b <= len; b++) begin
          m_rid = id; m_rdata = 64'(a) + 64'(b);
          m_rresp = 2'b00; m_rlast = (b == len); m_rvalid = 1'b1;
          k = 0;
          do begin @(negedge clk); k++; end
          while (!m_rready && k < 200);
          if (!m_rready) begin
            ncmp++; nerr++;
            $display("FAIL r wait: rready stuck at %b", m_rready);
          end
          @(posedge clk); #1;
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
      end
    end
  end

  function automatic logic rdy(int k, int p);
    case (k)
      0: return (p != 0) ? s1_awready : s0_awready;
      1: return (p != 0) ? s1_wready  : s0_wready;
      2: return (p != 0) ? s1_bvalid  : s0_bvalid;
      3: return (p != 0) ? s1_arready : s0_arready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_rdy(int k, int p, string nm, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (rdy(k, p)) break;
      if (n >= 200) begin
        ncmp++; nerr++;
        $display("FAIL %s: no handshake on port %0d", nm, p);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic mwr(int p, logic [IW-1:0] id, logic [AW-1:0] a,
                     int len, output int lat);
    int n;
    s_awid[p] = id; s_awaddr[p] = a; s_awlen[p] = 8'(len);
    s_awsize[p] = 3'd3; s_awburst[p] = 2'b01;
    s_awprot[p] = 3'(p + 1); s_awvalid[p] = 1'b1;
    wait_rdy(0, p, "aw wait", lat);
    s_awvalid[p] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_wdata[p] = wd(a, b); s_wstrb[p] = '1;
      s_wlast[p] = (b == len); s_wvalid[p] = 1'b1;
      wait_rdy(1, p, "w wait", n);
    end
    s_wvalid[p] = 1'b0; s_wlast[p] = 1'b0;
    s_bready[p] = 1'b1;
    wait_rdy(2, p, "b wait", n);
    s_bready[p] = 1'b0;
  endtask

  task automatic mrd(int p, logic [IW-1:0] id, logic [AW-1:0] a,
                     int len, bit tog);
    int n;
    bit done;
    s_arid[p] = id; s_araddr[p] = a; s_arlen[p] = 8'(len);
    s_arsize[p] = 3'd3; s_arburst[p] = 2'b01;
    s_arprot[p] = 3'(p + 1); s_arvalid[p] = 1'b1;
    wait_rdy(3, p, "ar wait", n);
    s_arvalid[p] = 1'b0;
    s_rready[p] = 1'b1;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (tog && p == 0 && s0_rvalid)
        chk("rready mirror", 128'(m_rready), 128'(s_rready[0]));
      if (((p != 0) ? (s1_rvalid && s1_rlast)
                    : (s0_rvalid && s0_rlast)) && s_rready[p])
        done = 1'b1;
      if (!done && n >= 300) begin
        ncmp++; nerr++;
        $display("FAIL r last: port %0d never finished", p);
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (tog) s_rready[p] = ~s_rready[p];
    end
    s_rready[p] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran past its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, l1, n;
    logic [AW-1:0] ra0 [3];
    logic [AW-1:0] ra1 [2];
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_awburst = '0; s_awcache = '0; s_awprot = '0;
    s_awlock = '0; s_awvalid = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_arburst = '0; s_arcache = '0; s_arprot = '0;
    s_arlock = '0; s_arvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
    s_bready = '0; s_rready = '0;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0;
    m_rlast = 1'b0; m_rvalid = 1'b0;
    aw_cyc = '{0, 0}; ar_cyc = '{0, 0}; b_cyc = '{0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset idle", 128'(vr), 128'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // simultaneous writes: s0 first, s1 two cycles after s0's B
    exp_wr(0, 4'h1, 32'h0000_1000, 1);
    exp_wr(1, 4'h2, 32'h0000_2000, 1);
    fork
      mwr(0, 4'h1, 32'h0000_1000, 1, l0);
      mwr(1, 4'h2, 32'h0000_2000, 1, l1);
    join
    chk("wr gap", 128'(aw_cyc[1] - b_cyc[0]), 128'd2);
    exp_wr(0, 4'h3, 32'h0000_1100, 0);
    exp_wr(1, 4'h4, 32'h0000_2100, 0);
    fork
      mwr(0, 4'h3, 32'h0000_1100, 0, l0);
      mwr(1, 4'h4, 32'h0000_2100, 0, l1);
    join

    // s0 streams reads while s1 keeps asking: grants alternate
    ra0 = '{32'h3000, 32'h3100, 32'h3200};
    ra1 = '{32'h4000, 32'h4100};
    exp_rd(0, 4'h5, ra0[0], 1);
    exp_rd(1, 4'h6, ra1[0], 1);
    exp_rd(0, 4'h5, ra0[1], 1);
    exp_rd(1, 4'h6, ra1[1], 1);
    exp_rd(0, 4'h5, ra0[2], 1);
    fork
      begin
        for (int i = 0; i < 3; i++) mrd(0, 4'h5, ra0[i], 1, 1'b0);
      end
      begin
        for (int j = 0; j < 2; j++) mrd(1, 4'h6, ra1[j], 1, 1'b0);
      end
    join

    // s1 write and s0 read in parallel
    exp_wr(1, 4'h7, 32'h0000_5000, 3);
    exp_rd(0, 4'h8, 32'h0000_6000, 3);
    fork
      mwr(1, 4'h7, 32'h0000_5000, 3, l1);
      mrd(0, 4'h8, 32'h0000_6000, 3, 1'b0);
    join
    chk("parallel grant", 128'(aw_cyc[1]), 128'(ar_cyc[0]));

    // R backpressure from s0
    exp_rd(0, 4'h9, 32'h0000_7000, 3);
    mrd(0, 4'h9, 32'h0000_7000, 3, 1'b1);

    // lone s0 write: one bubble cycle, s1 untouched
    s1_seen = 1'b0;
    exp_wr(0, 4'hA, 32'h0000_0100, 3);
    mwr(0, 4'hA, 32'h0000_0100, 3, l0);
    chk("aw latency", 128'(l0), 128'd2);
    chk("s1 quiet", 128'(s1_seen), 128'd0);

    // reset in the middle of a 4-beat write data phase
    begin
      a_t ea;
      w_t ew;
      ea.sel = 2'b01; ea.id = 4'hB; ea.addr = 32'h8000;
      ea.len = 8'd3; ea.prot = 3'd1;
      qaw.push_back(ea);
      for (int b = 0; b < 2; b++) begin
        ew.sel = 2'b01; ew.data = wd(32'h8000, b);
        ew.strb = '1; ew.last = 1'b0;
        qw.push_back(ew);
      end
    end
    s_awid[0] = 4'hB; s_awaddr[0] = 32'h8000; s_awlen[0] = 8'd3;
    s_awprot[0] = 3'd1; s_awvalid[0] = 1'b1;
    wait_rdy(0, 0, "aw wait", n);
    s_awvalid[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_wdata[0] = wd(32'h8000, b); s_wstrb[0] = '1;
      s_wlast[0] = 1'b0; s_wvalid[0] = 1'b1;
      wait_rdy(1, 0, "w wait", n);
    end
    s_wdata[0] = wd(32'h8000, 2);
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset", 128'(vr), 128'd0);
    s_wvalid[0] = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // pointers restart favouring s0
    exp_wr(0, 4'hC, 32'h0000_9000, 0);
    exp_wr(1, 4'hD, 32'h0000_9100, 0);
    fork
      mwr(0, 4'hC, 32'h0000_9000, 0, l0);
      mwr(1, 4'hD, 32'h0000_9100, 0, l1);
    join
    exp_rd(0, 4'h1, 32'h0000_A000, 0);
    exp_rd(1, 4'h2, 32'h0000_A100, 0);
    fork
      mrd(0, 4'h1, 32'h0000_A000, 0, 1'b0);
      mrd(1, 4'h2, 32'h0000_A100, 0, 1'b0);
    join

    // lone s1 while the pointer favours s0
    exp_wr(1, 4'hE, 32'h0000_9200, 0);
    mwr(1, 4'hE, 32'h0000_9200, 0, l1);
    chk("s1 alone latency", 128'(l1), 128'd2);

    repeat (4) @(posedge clk);
    #1;
    chk("aw drained", 128'(qaw.size()), 128'd0);
    chk("w drained", 128'(qw.size()), 128'd0);
    chk("b drained", 128'(qb.size()), 128'd0);
    chk("ar drained", 128'(qar.size()), 128'd0);
    chk("r drained", 128'(qr.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
